// File: rtl/bidir_bus_arb.sv
// bidir_bus_arb: two-sided arbiter for a shared bidirectional bus.
// Side A and side C take turns owning the bus. Ownership changes always
// pass through a dead TURN window of TURN_CYC cycles with the bus released.
// Optional contention checker: define BIDIR_CONTENTION_CHK_EN to build it;
// otherwise err is tied low.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | bus released, evaluating requests
// OWN_A | side A drives the bus, side C captures it into rdata_c
// OWN_C | side C drives the bus, side A captures it into rdata_a
// TURN  | dead cycles between owners, bus released, requests ignored
module bidir_bus_arb #(
    parameter int WIDTH    = 8,
    parameter int TURN_CYC = 2,
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_a,
    input  logic             req_c,
    input  logic [WIDTH-1:0] wdata_a,
    input  logic [WIDTH-1:0] wdata_c,
    inout  wire  [WIDTH-1:0] bus,
    output logic             gnt_a,
    output logic             gnt_c,
    output logic [WIDTH-1:0] rdata_a,
    output logic [WIDTH-1:0] rdata_c,
    output logic             err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_C = 2'd2,
        TURN  = 2'd3
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
    localparam logic [3:0] TURN_LAST = 4'(TURN_CYC - 1);

    state_t           state_q, state_d;
    logic [7:0]       hold_cnt_q, hold_cnt_d;
    logic [3:0]       turn_cnt_q, turn_cnt_d;
    logic             last_c_q, last_c_d;     // 1: side C owned the bus last
    logic             gnt_a_q, gnt_c_q;
    logic [WIDTH-1:0] rdata_a_q, rdata_c_q;

    // Only the registered owner drives the bus.
    assign bus = gnt_a_q ? wdata_a :
                 gnt_c_q ? wdata_c : {WIDTH{1'bz}};

    assign gnt_a   = gnt_a_q;
    assign gnt_c   = gnt_c_q;
    assign rdata_a = rdata_a_q;
    assign rdata_c = rdata_c_q;

    // State, counters, fairness bit and registered grants.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            hold_cnt_q <= '0;
            turn_cnt_q <= '0;
            last_c_q   <= 1'b1;
            gnt_a_q    <= 1'b0;
            gnt_c_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            turn_cnt_q <= turn_cnt_d;
            last_c_q   <= last_c_d;
            gnt_a_q    <= (state_d == OWN_A);
            gnt_c_q    <= (state_d == OWN_C);
        end
    end

    // Next-state logic: fair tie-break, preemption after MAX_HOLD cycles, fixed turnaround.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        turn_cnt_d = turn_cnt_q;
        last_c_d   = last_c_q;
        case (state_q)
            IDLE: begin
                if (req_a && (!req_c || last_c_q)) begin
                    state_d    = OWN_A;
                    hold_cnt_d = '0;
                    last_c_d   = 1'b0;
                end else if (req_c) begin
                    state_d    = OWN_C;
                    hold_cnt_d = '0;
                    last_c_d   = 1'b1;
                end
            end
            OWN_A, OWN_C: begin
                // hold_cnt saturates, so a late request from the other side
                // can preempt a long-running owner on its first cycle.
                if (hold_cnt_q != HOLD_LAST) begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end
                if (state_q == OWN_A) begin
                    if (!req_a || (req_c && hold_cnt_q == HOLD_LAST)) begin
                        state_d    = TURN;
                        turn_cnt_d = '0;
                    end
                end else begin
                    if (!req_c || (req_a && hold_cnt_q == HOLD_LAST)) begin
                        state_d    = TURN;
                        turn_cnt_d = '0;
                    end
                end
            end
            TURN: begin
                if (turn_cnt_q == TURN_LAST) begin
                    state_d    = IDLE;
                    turn_cnt_d = '0;
                end else begin
                    turn_cnt_d = turn_cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Each side captures what the other side drives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_a_q <= '0;
            rdata_c_q <= '0;
        end else begin
            if (gnt_a_q) begin
                rdata_c_q <= bus;
            end
            if (gnt_c_q) begin
                rdata_a_q <= bus;
            end
        end
    end

`ifdef BIDIR_CONTENTION_CHK_EN
    logic err_q;

    assign err = err_q;

    // Sticky flag: the owner's bus reads back something other than what it drives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if ((gnt_a_q && (bus !== wdata_a)) ||
                     (gnt_c_q && (bus !== wdata_c))) begin
            err_q <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_bidir_bus_arb.sv
// Directed bench for bidir_bus_arb (WIDTH=8, TURN_CYC=2, MAX_HOLD=16).
// The bus is pulled up, so a released bus reads 8'hFF; drive data is never FF
// except in the contention case.
module tb_bidir_bus_arb;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_a = 1'b0;
    logic       req_c = 1'b0;
    logic [7:0] wdata_a = 8'h00;
    logic [7:0] wdata_c = 8'h00;
    wire  [7:0] bus;
    logic       gnt_a, gnt_c, err;
    logic [7:0] rdata_a, rdata_c;
    logic       tb_drv_en = 1'b0;
    logic [7:0] tb_drv_val = 8'h00;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [7:0] BUS_Z = 8'hFF;

    bidir_bus_arb #(.WIDTH(8), .TURN_CYC(2), .MAX_HOLD(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .req_a   (req_a),
        .req_c   (req_c),
        .wdata_a (wdata_a),
        .wdata_c (wdata_c),
        .bus     (bus),
        .gnt_a   (gnt_a),
        .gnt_c   (gnt_c),
        .rdata_a (rdata_a),
        .rdata_c (rdata_c),
        .err     (err)
    );

    assign bus = tb_drv_en ? tb_drv_val : 8'bz;

    for (genvar g = 0; g < 8; g++) begin : g_pu
        pullup (bus[g]);
    end

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int own_cnt;
        logic done;

        // reset state
        #12;
        check("rst_gnt_a", gnt_a, 0);
        check("rst_gnt_c", gnt_c, 0);
        check("rst_bus_z", bus, BUS_Z);
        check("rst_err", err, 0);
        rst = 1'b0;
        tick();

        // single requester A, wdata A5
        req_a = 1'b1; wdata_a = 8'hA5;
        tick();
        check("a_gnt_a", gnt_a, 1);
        check("a_gnt_c", gnt_c, 0);
        check("a_bus", bus, 8'hA5);
        check("a_rdata_c_early", rdata_c, 8'h00);
        tick();
        check("a_rdata_c", rdata_c, 8'hA5);
        check("a_gnt_c_still0", gnt_c, 0);
        req_a = 1'b0;
        tick();
        check("a_turn_gnt", gnt_a, 0);
        check("a_turn_bus", bus, BUS_Z);
        tick(2);

        // tie after reset: A first, then C after TURN(2) and IDLE
        rst = 1'b1; #2; rst = 1'b0;
        tick();
        req_a = 1'b1; req_c = 1'b1; wdata_a = 8'h3C; wdata_c = 8'hC3;
        tick();
        check("tie_gnt_a", gnt_a, 1);
        check("tie_gnt_c", gnt_c, 0);
        check("tie_bus_a", bus, 8'h3C);
        req_a = 1'b0;
        tick();
        check("tie_turn1_bus", bus, BUS_Z);
        check("tie_turn1_gnt_c", gnt_c, 0);
        tick();
        check("tie_turn2_bus", bus, BUS_Z);
        check("tie_turn2_gnt_c", gnt_c, 0);
        tick();
        check("tie_idle_gnt_c", gnt_c, 0);
        tick();
        check("tie_own_c", gnt_c, 1);
        check("tie_bus_c", bus, 8'hC3);
        tick();
        check("tie_rdata_a", rdata_a, 8'hC3);
        req_c = 1'b0;
        tick(3);

        // preemption: A held, C requesting from cycle 3
        req_a = 1'b1; wdata_a = 8'h5A;
        own_cnt = 0;
        done = 1'b0;
        for (int i = 1; i <= 40 && !done; i++) begin
            tick();
            if (gnt_a) own_cnt++;
            else if (i > 1) done = 1'b1;
            if (i == 3) req_c = 1'b1;
        end
        check("pre_done", done, 1);
        check("pre_own_cycles", own_cnt, 16);
        check("pre_turn1_bus", bus, BUS_Z);
        tick();
        check("pre_turn2_gnt_c", gnt_c, 0);
        tick();
        check("pre_idle_gnt_c", gnt_c, 0);
        tick();
        check("pre_own_c", gnt_c, 1);
        check("pre_own_c_gnt_a", gnt_a, 0);
        tick(2);
        check("pre_rdata_c", rdata_c, 8'h5A);

        // async reset mid OWN_C
        #2; rst = 1'b1; #1;
        check("arst_gnt_c", gnt_c, 0);
        check("arst_bus_z", bus, BUS_Z);
        check("arst_rdata_a", rdata_a, 8'h00);
        check("arst_rdata_c", rdata_c, 8'h00);
        #2; rst = 1'b0;
        tick();
        check("arst_idle_tie_a", gnt_a, 1);
        check("arst_idle_tie_c", gnt_c, 0);
        req_a = 1'b0; req_c = 1'b0;
        tick(3);

        // request dropped at the grant edge: one OWN cycle, TURN(2), IDLE
        req_a = 1'b1; wdata_a = 8'h11;
        tick();
        check("pulse_gnt", gnt_a, 1);
        req_a = 1'b0;
        tick();
        check("pulse_turn1", gnt_a, 0);
        req_c = 1'b1; wdata_c = 8'h22;
        tick();
        check("pulse_turn2_gnt_c", gnt_c, 0);
        tick();
        check("pulse_idle_gnt_c", gnt_c, 0);
        tick();
        check("pulse_own_c", gnt_c, 1);
        req_c = 1'b0;
        tick(3);

        // no time limit without competition; saturated hold_cnt then preempts at once
        req_a = 1'b1; wdata_a = 8'h44;
        tick(21);
        check("hold_long_gnt_a", gnt_a, 1);
        req_c = 1'b1;
        tick();
        check("hold_sat_preempt", gnt_a, 0);
        req_a = 1'b0; req_c = 1'b0;
        tick(3);

        // contention: external driver forces 00 while A drives FF
        req_a = 1'b1; wdata_a = 8'hFF;
        tick();
        check("cont_gnt_a", gnt_a, 1);
        tb_drv_en = 1'b1; tb_drv_val = 8'h00;
        tick();
        tb_drv_en = 1'b0;
        req_a = 1'b0;
        tick(2);
`ifdef BIDIR_CONTENTION_CHK_EN
        check("cont_err_sticky", err, 1);
`else
        check("cont_err_tied", err, 0);
`endif
        rst = 1'b1; #2; rst = 1'b0;
        check("cont_err_rst", err, 0);
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bidir_bus_arb.md
BIDIR_BUS_ARB -- requirements
Module: bidir_bus_arb

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: shared bus width in bits.
REQ-002 The block SHALL have parameter TURN_CYC, default 2, legal range 1..15: number of dead cycles between bus owners.
REQ-003 The block SHALL have parameter MAX_HOLD, default 16, legal range 2..255: maximum number of owner cycles while the other side is requesting.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 req_a  input  1  side A requests to drive the bus.
REQ-007 req_c  input  1  side C requests to drive the bus.
REQ-008 wdata_a  input  WIDTH  data that side A drives onto the bus.
REQ-009 wdata_c  input  WIDTH  data that side C drives onto the bus.
REQ-010 bus  inout  WIDTH  shared bidirectional bus; driven only by the current owner, otherwise high-Z.
REQ-011 gnt_a  output  1  side A owns the bus this cycle.
REQ-012 gnt_c  output  1  side C owns the bus this cycle.
REQ-013 rdata_a  output  WIDTH  bus value captured for side A while C owns the bus.
REQ-014 rdata_c  output  WIDTH  bus value captured for side C while A owns the bus.
REQ-015 err  output  1  sticky contention flag (see Configuration).

Function
REQ-016 The FSM SHALL have exactly four states: IDLE, OWN_A, OWN_C and TURN.
REQ-017 gnt_a SHALL be 1 exactly when state is OWN_A, and gnt_c SHALL be 1 exactly when state is OWN_C; both grants SHALL be registered outputs and SHALL never be 1 at the same time.
REQ-018 The bus SHALL carry wdata_a when gnt_a=1, wdata_c when gnt_c=1, and high-Z in IDLE and TURN.
REQ-019 In IDLE, a single requester SHALL move the FSM to that side's OWN state on the next edge, giving a request-to-grant latency of 1 cycle.
REQ-020 In IDLE with both requests high, the side not recorded in last_owner SHALL win; last_owner SHALL update on every entry into an OWN state.
REQ-021 In OWN_x, the FSM SHALL stay while req_x=1 and, if the other side is requesting, while hold_cnt < MAX_HOLD-1.
REQ-022 hold_cnt SHALL clear to 0 on entry into an OWN state, SHALL increment once per OWN cycle, and SHALL saturate at MAX_HOLD-1.
REQ-023 In OWN_x, the FSM SHALL go to TURN when req_x=0, or when the other side is requesting and hold_cnt = MAX_HOLD-1 (preemption).
REQ-024 If the other side is not requesting, the owner SHALL hold the bus with no time limit.
REQ-025 TURN SHALL last exactly TURN_CYC cycles, counted by turn_cnt, then go to IDLE; requests during TURN SHALL be ignored.
REQ-026 Every exit from an OWN state SHALL pass through TURN, including the case where the same side re-requests.
REQ-027 rdata_c SHALL capture the bus on each edge where gnt_a=1, and rdata_a SHALL capture the bus on each edge where gnt_c=1; otherwise both SHALL hold their values.
REQ-028 A request dropped at the same edge the grant is issued SHALL still produce one OWN cycle, followed by TURN.

Reset
REQ-029 rst=1 SHALL immediately, without waiting for a clock edge, force state=IDLE, gnt_a=0, gnt_c=0, bus=high-Z, hold_cnt=0, turn_cnt=0, last_owner=C (so A wins the first tie), rdata_a=0, rdata_c=0 and err=0.
REQ-030 Reset asserted mid-ownership or mid-TURN SHALL abandon the transfer; after rst deasserts, the first evaluation SHALL happen in IDLE.

Configuration
REQ-031 The block SHALL use one macro, BIDIR_CONTENTION_CHK_EN, to control the contention checker.
REQ-032 With BIDIR_CONTENTION_CHK_EN defined, err SHALL set on any edge where gnt_x=1 and the sampled bus differs from wdata_x (contention or X/Z); err SHALL stay set until rst.
REQ-033 With BIDIR_CONTENTION_CHK_EN undefined, the err port SHALL remain and SHALL be tied to 0, with no checker logic present.

Verification
REQ-034 req_a=1 alone at cycle 0 with wdata_a=8'hA5 -> gnt_a=1 from cycle 1, bus=A5, rdata_c=A5 one edge later, gnt_c=0 throughout.
REQ-035 req_a and req_c both rise in the same IDLE cycle after reset -> A is granted first; A drops -> TURN for exactly 2 cycles with bus=Z -> IDLE -> C is granted.
REQ-036 req_a held high with req_c high from cycle 3 -> A is preempted after 16 OWN cycles -> TURN(2) -> IDLE -> OWN_C.
REQ-037 rst pulsed during OWN_C between clock edges -> gnt_c=0 and bus=Z before the next edge; after release the FSM is in IDLE with all counters at 0.
REQ-038 With BIDIR_CONTENTION_CHK_EN defined, an external driver forces bus=8'h00 while gnt_a=1 and wdata_a=8'hFF -> err=1 at the next edge and stays 1 until rst; the same stimulus with the macro undefined -> err=0.
REQ-039 req_a pulses for 1 cycle exactly at the grant edge -> one OWN_A cycle, then TURN_CYC cycles of TURN, then IDLE.
